// File: rtl/prescaler_bank.sv
// Bank of independent clock prescalers with shadowed scale/mode reload and
// toggle (50% duty) or single-cycle pulse output per channel.
module prescaler_bank #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*WIDTH-1:0] clkscale,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH-1:0]       sync,
  output logic [NCH-1:0]       sclclk,
  output logic [NCH-1:0]       tick
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_scale;
    logic             act_mode;
    logic             sclk_q;
    logic             tick_q;
    logic [WIDTH-1:0] deff_c;
    logic             term_c;

    // A scale of zero divides by one.
    always_comb begin
      deff_c = (act_scale == '0) ? WIDTH'(1) : act_scale;
      term_c = (cnt == deff_c - WIDTH'(1));
    end

    always_ff @(posedge CLK) begin
      if (RST || sync[i]) begin
        cnt       <= '0;
        sclk_q    <= 1'b0;
        tick_q    <= 1'b0;
        act_scale <= clkscale[i*WIDTH +: WIDTH];
        act_mode  <= mode[i];
      end else if (en[i]) begin
        if (term_c) begin
          // Shadow registers only reload here so a period is never cut short.
          cnt       <= '0;
          tick_q    <= 1'b1;
          act_scale <= clkscale[i*WIDTH +: WIDTH];
          act_mode  <= mode[i];
          if (mode[i])
            sclk_q <= 1'b1;
          else if (act_mode)
            sclk_q <= 1'b0;
          else
            sclk_q <= ~sclk_q;
        end else begin
          cnt    <= cnt + WIDTH'(1);
          tick_q <= 1'b0;
          if (act_mode)
            sclk_q <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign sclclk[i] = sclk_q;
    assign tick[i]   = tick_q;
  end

endmodule

// File: tb/tb_prescaler_bank.sv
// Directed self-checking bench for prescaler_bank (NCH=2, WIDTH=8).
module tb_prescaler_bank;

  localparam int unsigned NCH   = 2;
  localparam int unsigned WIDTH = 8;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [NCH-1:0]       en;
  logic [NCH*WIDTH-1:0] clkscale;
  logic [NCH-1:0]       mode;
  logic [NCH-1:0]       sync;
  logic [NCH-1:0]       sclclk;
  logic [NCH-1:0]       tick;

  int n_checks = 0;
  int n_pass   = 0;

  prescaler_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .en(en), .clkscale(clkscale),
    .mode(mode), .sync(sync), .sclclk(sclclk), .tick(tick)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Restart channel 0 with a new scale and mode via sync.
  task automatic sync0(input logic [WIDTH-1:0] d, input logic m);
    clkscale[WIDTH-1:0] = d;
    mode[0] = m;
    sync[0] = 1'b1;
    step();
    sync[0] = 1'b0;
    check("sync_tick0", 32'(tick[0]), 0);
    check("sync_sclk0", 32'(sclclk[0]), 0);
  endtask

  initial begin
    RST = 1'b1; en = '0; sync = '0; mode = 2'b10;
    clkscale = {8'd4, 8'd3};
    step(); step();
    check("rst_tick", 32'(tick), 0);
    check("rst_sclk", 32'(sclclk), 0);

    // ch0 D=3 toggle, ch1 D=4 pulse, free running from reset release.
    RST = 1'b0; en = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("t0_e%0d", k), 32'(tick[0]),   32'((k % 3) == 0));
      check($sformatf("s0_e%0d", k), 32'(sclclk[0]), 32'((k / 3) % 2));
      check($sformatf("t1_e%0d", k), 32'(tick[1]),   32'((k % 4) == 0));
      check($sformatf("s1_e%0d", k), 32'(sclclk[1]), 32'((k % 4) == 0));
    end

    // D=5, scale changed to 2 mid-period: ticks at edges 5, 7, 9.
    sync0(8'd5, 1'b0);
    step();
    clkscale[WIDTH-1:0] = 8'd2;
    for (int k = 2; k <= 10; k++) begin
      step();
      check($sformatf("upd_t_e%0d", k), 32'(tick[0]), 32'(k == 5 || k == 7 || k == 9));
      check($sformatf("upd_s_e%0d", k), 32'(sclclk[0]), 32'(k >= 5 && k < 7 || k >= 9));
    end

    // D=0 and D=1 behave identically: tick every edge, sclclk alternates.
    for (int d = 0; d <= 1; d++) begin
      sync0(8'(d), 1'b0);
      for (int k = 1; k <= 4; k++) begin
        step();
        check($sformatf("d%0d_t_e%0d", d, k), 32'(tick[0]), 1);
        check($sformatf("d%0d_s_e%0d", d, k), 32'(sclclk[0]), 32'(k % 2));
      end
    end

    // Pulse mode with Deff=1 holds sclclk high.
    sync0(8'd1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("p1_s_e%0d", k), 32'(sclclk[0]), 1);
    end

    // Mode switches at terminal events, D=2.
    sync0(8'd2, 1'b0);
    step();
    mode[0] = 1'b1;
    step(); check("m01_sclk", 32'(sclclk[0]), 1); check("m01_tick", 32'(tick[0]), 1);
    step(); check("m1_low", 32'(sclclk[0]), 0);
    step(); check("m1_high", 32'(sclclk[0]), 1);
    mode[0] = 1'b0;
    step(); check("m1_e5", 32'(sclclk[0]), 0);
    step(); check("m10_sclk", 32'(sclclk[0]), 0); check("m10_tick", 32'(tick[0]), 1);
    step(); check("m0_hold", 32'(sclclk[0]), 0);
    step(); check("m0_toggle", 32'(sclclk[0]), 1);

    // Enable dropped for 4 cycles at cnt=1 delays the terminal by 4.
    sync0(8'd3, 1'b0);
    step();
    en[0] = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      step();
      check($sformatf("en_t_e%0d", k), 32'(tick[0]), 0);
      check($sformatf("en_s_e%0d", k), 32'(sclclk[0]), 0);
    end
    en[0] = 1'b1;
    step(); check("en_e6_tick", 32'(tick[0]), 0);
    step(); check("en_e7_tick", 32'(tick[0]), 1); check("en_e7_sclk", 32'(sclclk[0]), 1);

    // Sync on the terminal edge suppresses the tick and restarts the period.
    step(); step();
    sync[0] = 1'b1;
    step(); check("syt_tick", 32'(tick[0]), 0); check("syt_sclk", 32'(sclclk[0]), 0);
    sync[0] = 1'b0;
    step(); check("syt_e1", 32'(tick[0]), 0);
    step(); check("syt_e2", 32'(tick[0]), 0);
    step(); check("syt_e3", 32'(tick[0]), 1);

    // Reset mid-period clears all outputs on that edge.
    step();
    RST = 1'b1;
    step();
    check("rstmid_tick", 32'(tick), 0);
    check("rstmid_sclk", 32'(sclclk), 0);
    RST = 1'b0;
    step(); step();
    check("rstpost_tick", 32'(tick[0]), 0);
    step();
    check("rstpost_tick3", 32'(tick[0]), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
